// File: rtl/urv_muldiv_seq.sv
// urv_muldiv_seq
//   Sequential RV32M multiply/divide unit for the uRV execute stage. One
//   radix-2^k engine is shared by MUL/MULH/MULHSU/MULHU and
//   DIV/DIVU/REM/REMU. The engine works on operand magnitudes and applies
//   the sign correction when it loads the result register. Divide by zero,
//   signed overflow and (without MULH support) the MULH* group bypass the
//   engine and load the result in the start cycle.
//
// Parameters
//   g_width          operand/result width (multiple of g_bits_per_cycle)
//   g_bits_per_cycle bits retired per BUSY cycle: 1, 2 or 4
//   g_with_mulh      1: MULH/MULHSU/MULHU supported, 0: they return 0
//
// Ports
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   x_stall_i        global X-stage stall (only used to leave DONE)
//   x_kill_i         kill the instruction currently in X
//   d_valid_i        instruction in X is valid
//   d_is_multiply_i  instruction is MUL*
//   d_is_divide_i    instruction is DIV*/REM*
//   d_fun_i          funct3 selecting the operation
//   d_rs1_i, d_rs2_i operands a (dividend/multiplicand), b (divisor/multiplier)
//   x_stall_req_o    stall request towards pipeline control
//   x_rd_o           registered result
//   x_busy_o         engine not idle
module urv_muldiv_seq #(
    parameter int g_width          = 32,
    parameter int g_bits_per_cycle = 1,
    parameter int g_with_mulh      = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               x_stall_i,
    input  logic               x_kill_i,
    input  logic               d_valid_i,
    input  logic               d_is_multiply_i,
    input  logic               d_is_divide_i,
    input  logic [2:0]         d_fun_i,
    input  logic [g_width-1:0] d_rs1_i,
    input  logic [g_width-1:0] d_rs2_i,
    output logic               x_stall_req_o,
    output logic [g_width-1:0] x_rd_o,
    output logic               x_busy_o
);

    localparam int W  = g_width;
    localparam int K  = g_bits_per_cycle;
    localparam int N  = W / K;
    localparam int CW = $clog2(N + 1);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // opa: multiplicand magnitude, or dividend shifting into the quotient
    logic [W-1:0]    opa_q, opa_d;
    // opb: multiplier consumed MSB-first, or divisor magnitude
    logic [W-1:0]    opb_q, opb_d;
    // acc: 2W product accumulator; bits [W:0] hold the partial remainder
    logic [2*W-1:0]  acc_q, acc_d;
    logic            is_div_q, is_div_d;
    // sel: high product half for MULH*, remainder for REM*
    logic            sel_q, sel_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    rd_q, rd_d;
    logic            busy_q, busy_d;

    // funct3[2] duplicates d_is_divide_i, so only the low bits are decoded
    logic unused_fun;
    assign unused_fun = d_fun_i[2];

    logic         start;
    logic         op_div;
    logic         signed_a, signed_b;
    logic         a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         start_sel, start_neg;
    logic         div_zero, div_ovf, mulh_off, special;
    logic [W-1:0] special_res;

    assign start  = (state_q == ST_IDLE) && d_valid_i &&
                    (d_is_multiply_i || d_is_divide_i) && !x_kill_i;
    assign op_div = d_is_divide_i;

    // Multiply: MULH is s*s, MULHSU s*u, MUL/MULHU treated as unsigned
    // (the low half of MUL does not depend on signedness).
    assign signed_a = op_div ? !d_fun_i[0] : (d_fun_i[1] ^ d_fun_i[0]);
    assign signed_b = op_div ? !d_fun_i[0] : (!d_fun_i[1] && d_fun_i[0]);
    assign a_neg    = signed_a && d_rs1_i[W-1];
    assign b_neg    = signed_b && d_rs2_i[W-1];
    assign a_mag    = a_neg ? -d_rs1_i : d_rs1_i;
    assign b_mag    = b_neg ? -d_rs2_i : d_rs2_i;

    // The remainder follows the dividend's sign, everything else a^b.
    assign start_sel = op_div ? d_fun_i[1] : (d_fun_i[1:0] != 2'b00);
    assign start_neg = (op_div && start_sel) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = op_div && (d_rs2_i == '0);
    assign div_ovf  = op_div && !d_fun_i[0] && (d_rs1_i == MIN_VAL) &&
                      (d_rs2_i == '1);
    assign mulh_off = !op_div && start_sel && (g_with_mulh == 0);
    assign special  = div_zero || div_ovf || mulh_off;

    // Results that are known in the start cycle without iterating.
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = start_sel ? d_rs1_i : '1;
        end else if (div_ovf) begin
            special_res = start_sel ? '0 : MIN_VAL;
        end
    end

    logic [K-1:0]   mul_digit;
    logic [2*W-1:0] mul_acc;
    logic [2*W-1:0] mul_prod;
    logic [W:0]     step_rem;
    logic [W-1:0]   step_quo;
    logic [W-1:0]   div_pick;
    logic [W-1:0]   final_res;

    // One multiply step: Horner shift-add of the top k multiplier bits.
    assign mul_digit = opb_q[W-1 -: K];
    assign mul_acc   = (acc_q << K) +
                       ({{W{1'b0}}, opa_q} * {{(2*W-K){1'b0}}, mul_digit});

    // One divide step: k restoring shift-subtract iterations. The partial
    // remainder is one bit wider than the divisor so the shifted value never
    // overflows before the compare.
    always_comb begin
        step_rem = acc_q[W:0];
        step_quo = opa_q;
        for (int i = 0; i < K; i++) begin
            step_rem = {step_rem[W-1:0], step_quo[W-1]};
            step_quo = {step_quo[W-2:0], 1'b0};
            if (step_rem >= {1'b0, opb_q}) begin
                step_rem    = step_rem - {1'b0, opb_q};
                step_quo[0] = 1'b1;
            end
        end
    end

    // Sign-corrected result, valid during the last BUSY step.
    always_comb begin
        mul_prod = neg_q ? -mul_acc : mul_acc;
        div_pick = sel_q ? step_rem[W-1:0] : step_quo;
        if (is_div_q) begin
            final_res = neg_q ? -div_pick : div_pick;
        end else begin
            final_res = sel_q ? mul_prod[2*W-1:W] : mul_prod[W-1:0];
        end
    end

    // Next-state and datapath updates. Kill always wins and leaves the
    // result register untouched; DONE waits for the pipeline to move before
    // accepting a new instruction so the held one cannot restart.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        is_div_d = is_div_q;
        sel_d    = sel_q;
        neg_d    = neg_q;
        rd_d     = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (special) begin
                        rd_d    = special_res;
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_BUSY;
                        cnt_d    = CW'(N);
                        opa_d    = a_mag;
                        opb_d    = b_mag;
                        acc_d    = '0;
                        is_div_d = op_div;
                        sel_d    = start_sel;
                        neg_d    = start_neg;
                    end
                end
            end
            ST_BUSY: begin
                if (x_kill_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        opa_d = step_quo;
                        acc_d = {{(W-1){1'b0}}, step_rem};
                    end else begin
                        opb_d = opb_q << K;
                        acc_d = mul_acc;
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rd_d    = final_res;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (x_kill_i || !x_stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            is_div_q <= 1'b0;
            sel_q    <= 1'b0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            is_div_q <= is_div_d;
            sel_q    <= sel_d;
            neg_q    <= neg_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
        end
    end

    assign x_stall_req_o = start || (state_q == ST_BUSY);
    assign x_rd_o        = rd_q;
    assign x_busy_o      = busy_q;

endmodule

// File: tb/tb_urv_muldiv_seq.sv
// Testbench for urv_muldiv_seq: four instances (k=1, k=2, k=4, and k=4
// without MULH support) share clock, reset and operand buses; each has its
// own valid line so only the addressed instance sees an instruction.
module tb_urv_muldiv_seq;

    localparam int NDUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstN;
    logic            xStall;
    logic            xKill;
    logic            isMul;
    logic            isDiv;
    logic [2:0]      fun;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    logic [NDUT-1:0] valid;
    logic [NDUT-1:0] stallReq;
    logic [NDUT-1:0] busy;
    logic [31:0]     rd [NDUT];

    int assertions = 0;
    int failures   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        urv_muldiv_seq #(
            .g_width         (32),
            .g_bits_per_cycle(g == 0 ? 1 : (g == 1 ? 2 : 4)),
            .g_with_mulh     (g == 3 ? 0 : 1)
        ) u_dut (
            .clk_i          (clk),
            .rst_n_i        (rstN),
            .x_stall_i      (xStall),
            .x_kill_i       (xKill),
            .d_valid_i      (valid[g]),
            .d_is_multiply_i(isMul),
            .d_is_divide_i  (isDiv),
            .d_fun_i        (fun),
            .d_rs1_i        (rs1),
            .d_rs2_i        (rs2),
            .x_stall_req_o  (stallReq[g]),
            .x_rd_o         (rd[g]),
            .x_busy_o       (busy[g])
        );
    end

    function automatic int bitsPerCycle(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 2 : 4);
    endfunction

    // Behavioural RV32M reference built from plain 32/64-bit arithmetic.
    function automatic void refModel(input logic opDiv, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input bit withMulh,
                                     output logic [31:0] res, output bit special);
        int          ia;
        int          ib;
        longint      sa;
        logic [63:0] p;
        ia      = int'(a);
        ib      = int'(b);
        sa      = longint'(ia);
        special = 1'b0;
        res     = '0;
        if (opDiv) begin
            if (b == 32'h0) begin
                special = 1'b1;
                res     = f[1] ? a : 32'hFFFF_FFFF;
            end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                special = 1'b1;
                res     = f[1] ? 32'h0 : 32'h8000_0000;
            end else begin
                case (f[1:0])
                    2'd0:    res = 32'(ia / ib);
                    2'd1:    res = a / b;
                    2'd2:    res = 32'(ia % ib);
                    default: res = a % b;
                endcase
            end
        end else begin
            if (f[1:0] != 2'd0 && !withMulh) begin
                special = 1'b1;
                res     = 32'h0;
            end else begin
                case (f[1:0])
                    2'd0: begin p = {32'h0, a} * {32'h0, b}; res = p[31:0];  end
                    2'd1: begin p = 64'(sa * longint'(ib));  res = p[63:32]; end
                    2'd2: begin p = 64'(sa * longint'({32'h0, b})); res = p[63:32]; end
                    default: begin p = {32'h0, a} * {32'h0, b}; res = p[63:32]; end
                endcase
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Presents an instruction to one instance at a falling edge.
    task automatic applyStimulus(input int idx, input logic opDiv, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        isMul      = !opDiv;
        isDiv      = opDiv;
        fun        = f;
        rs1        = a;
        rs2        = b;
        valid      = '0;
        valid[idx] = 1'b1;
    endtask

    // Issues one instruction, measures the stall-request length and checks
    // the result. With holdDone set the instance is left in DONE with the
    // instruction still in X.
    task automatic runOp(input string tag, input int idx, input logic opDiv,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit useModel, input logic [31:0] expConst,
                         input bit holdDone);
        logic [31:0] expRes;
        bit          special;
        int          cycles;
        int          expCycles;
        refModel(opDiv, f, a, b, (idx != 3), expRes, special);
        if (!useModel) expRes = expConst;
        expCycles = special ? 1 : (32 / bitsPerCycle(idx)) + 1;
        applyStimulus(idx, opDiv, f, a, b);
        cycles = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!stallReq[idx]) break;
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_stall"}, 32'(cycles), 32'(expCycles));
        checkOutput({tag, "_rd"}, rd[idx], expRes);
        checkOutput({tag, "_busy_done"}, {31'h0, busy[idx]}, 32'h1);
        if (!holdDone) begin
            valid = '0;
            @(negedge clk);
            #1;
            checkOutput({tag, "_idle"}, {31'h0, busy[idx]}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rDiv;
        logic [2:0]  rFun;

        rstN   = 1'b0;
        xStall = 1'b0;
        xKill  = 1'b0;
        isMul  = 1'b0;
        isDiv  = 1'b0;
        fun    = 3'd0;
        rs1    = '0;
        rs2    = '0;
        valid  = '0;

        // Reset state of every instance.
        #12;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("reset_rd%0d", i), rd[i], 32'h0);
            checkOutput($sformatf("reset_busy%0d", i), {31'h0, busy[i]}, 32'h0);
            checkOutput($sformatf("reset_stall%0d", i), {31'h0, stallReq[i]}, 32'h0);
        end
        @(negedge clk);
        rstN = 1'b1;

        // Signed divide and remainder with a negative divisor.
        runOp("div_7_m2", 0, 1'b1, 3'd4, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 1'b0);
        runOp("rem_7_m2", 0, 1'b1, 3'd6, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'h1, 1'b0);

        // Divide by zero and signed overflow bypass the engine.
        runOp("divu_by0", 0, 1'b1, 3'd5, 32'd5, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        runOp("remu_by0", 0, 1'b1, 3'd7, 32'd5, 32'h0, 1'b0, 32'h5, 1'b0);
        runOp("div_ovf", 0, 1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0);
        runOp("rem_ovf", 0, 1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);

        // Multiply signedness variants.
        runOp("mulh_m1", 0, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        runOp("mulhu_m1", 0, 1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0);
        runOp("mulhsu", 0, 1'b0, 3'd2, 32'hFFFF_FFFF, 32'h2, 1'b0, 32'hFFFF_FFFF, 1'b0);
        runOp("mul_wrap", 0, 1'b0, 3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 1'b0);

        // Kill during the 10th BUSY cycle.
        saved = rd[0];
        applyStimulus(0, 1'b1, 3'd5, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        xKill = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("kill_stall", {31'h0, stallReq[0]}, 32'h0);
        checkOutput("kill_busy", {31'h0, busy[0]}, 32'h0);
        checkOutput("kill_rd", rd[0], saved);
        xKill = 1'b0;
        valid = '0;
        runOp("divu_100_7", 0, 1'b1, 3'd5, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0);

        // Kill in the start cycle prevents the start.
        applyStimulus(0, 1'b1, 3'd5, 32'd9, 32'd2);
        xKill = 1'b1;
        #1;
        checkOutput("kill_start_stall", {31'h0, stallReq[0]}, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("kill_start_busy", {31'h0, busy[0]}, 32'h0);
        xKill = 1'b0;
        valid = '0;

        // Held in DONE by the global stall: result stable, no restart.
        runOp("rem_hold", 0, 1'b1, 3'd6, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'h1, 1'b1);
        xStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("hold_rd%0d", i), rd[0], 32'h1);
            checkOutput($sformatf("hold_stall%0d", i), {31'h0, stallReq[0]}, 32'h0);
            checkOutput($sformatf("hold_busy%0d", i), {31'h0, busy[0]}, 32'h1);
        end
        xStall = 1'b0;
        valid  = '0;
        @(negedge clk);
        #1;
        checkOutput("hold_release_busy", {31'h0, busy[0]}, 32'h0);

        // Asynchronous reset in the middle of an operation.
        applyStimulus(0, 1'b1, 3'd5, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        valid = '0;
        rstN  = 1'b0;
        #1;
        checkOutput("rst_mid_rd", rd[0], 32'h0);
        checkOutput("rst_mid_busy", {31'h0, busy[0]}, 32'h0);
        checkOutput("rst_mid_stall", {31'h0, stallReq[0]}, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        runOp("after_rst", 0, 1'b1, 3'd5, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0);

        // Radix-16 engine and the MULH-less configuration.
        runOp("k4_div", 2, 1'b1, 3'd4, 32'd1000, 32'd3, 1'b0, 32'd333, 1'b0);
        runOp("k2_div", 1, 1'b1, 3'd4, 32'hFFFF_FC18, 32'd3, 1'b0, 32'hFFFF_FEB3, 1'b0);
        runOp("nomulh_mulhu", 3, 1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        runOp("nomulh_mul", 3, 1'b0, 3'd0, 32'd12345, 32'd678, 1'b0, 32'd8369910, 1'b0);

        // Random sweep against the reference model on every instance.
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 15; n++) begin
                rDiv = 1'($urandom_range(0, 1));
                rFun = {rDiv, 2'($urandom_range(0, 3))};
                ra   = $urandom;
                rb   = $urandom;
                case ($urandom_range(0, 7))
                    0: rb = 32'h0;
                    1: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
                    2: rb = 32'($urandom_range(1, 15));
                    3: rb = 32'hFFFF_FFFF;
                    default: ;
                endcase
                runOp($sformatf("rnd_d%0d_n%0d", d, n), d, rDiv, rFun, ra, rb,
                      1'b1, 32'h0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
